edge_event_detector: RTL and testbench

Multi-channel, parametrised edge detector. It replaces the single-mode rising-edge pulse generator in the IO path (buttons, switches, UART strobes). Each channel can detect rising edges, falling edges, or both. A detection produces a registered, stretchable pulse followed by an optional re-trigger lockout, and sets a sticky event flag that software or the FSM can clear. Typical use: it sits after the synchronizer/debouncer chain and feeds the MMIO event register and the CPU-side control logic.

---
 rtl/edge_event_detector_pkg.sv | 18 +
 rtl/edge_channel.sv | 93 +++++++++
 rtl/edge_event_detector.sv | 51 +++++
 tb/tb_edge_event_detector.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/edge_event_detector_pkg.sv
// rtl/edge_event_detector_pkg.sv - shared edge FSM state encoding and counter sizing
package edge_event_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PULSE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } edge_state_e;

  function automatic int edge_cnt_width(input int pulse_cycles, input int holdoff_cycles);
    int m;
    int w;
    m = (pulse_cycles > holdoff_cycles) ? pulse_cycles : holdoff_cycles;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// rtl/edge_channel.sv - one edge detector channel: prev sample, pulse/holdoff FSM, sticky flag
module edge_channel
  import edge_event_detector_pkg::*;
#(
  parameter int PULSE_CYCLES   = 1,
  parameter int HOLDOFF_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  input  logic mode_rise,
  input  logic mode_fall,
  input  logic sticky_clear,
  output logic edge_pulse,
  output logic edge_sticky,
  output logic pulse_next
);

  localparam int CW = edge_cnt_width(PULSE_CYCLES, HOLDOFF_CYCLES);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  edge_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            prev_q;
  logic            sticky_q;
  logic            qual;
  logic            expiring;
  logic            accept;

  assign qual = (signal_in & ~prev_q & mode_rise) | (~signal_in & prev_q & mode_fall);

  // The last cycle of the lockout counts as idle so an edge at exactly the
  // minimum spacing is still accepted.
  assign expiring = (cnt_q == '0) &&
                    ((state_q == ST_HOLDOFF) ||
                     ((state_q == ST_PULSE) && (HOLDOFF_CYCLES == 0)));
  assign accept   = qual && ((state_q == ST_IDLE) || expiring);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q   <= signal_in;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      prev_q   <= signal_in;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sticky_q <= qual | (sticky_q & ~sticky_clear);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: ;
      ST_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (HOLDOFF_CYCLES == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLDOFF;
          cnt_d   = HOLD_LOAD;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      state_d = ST_PULSE;
      cnt_d   = PULSE_LOAD;
    end
  end

  always_comb begin
    edge_pulse  = (state_q == ST_PULSE);
    pulse_next  = (state_d == ST_PULSE);
    edge_sticky = sticky_q;
  end

endmodule

// File: rtl/edge_event_detector.sv
// rtl/edge_event_detector.sv - multi-channel edge detector top with registered any-edge flag
module edge_event_detector
  import edge_event_detector_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int PULSE_CYCLES   = 1,
  parameter int HOLDOFF_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] signal_in,
  input  logic [WIDTH-1:0] mode_rise,
  input  logic [WIDTH-1:0] mode_fall,
  input  logic [WIDTH-1:0] sticky_clear,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] edge_sticky,
  output logic             edge_any
);

  logic [WIDTH-1:0] pulse_next;
  logic             any_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    edge_channel #(
      .PULSE_CYCLES  (PULSE_CYCLES),
      .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .signal_in   (signal_in[g]),
      .mode_rise   (mode_rise[g]),
      .mode_fall   (mode_fall[g]),
      .sticky_clear(sticky_clear[g]),
      .edge_pulse  (edge_pulse[g]),
      .edge_sticky (edge_sticky[g]),
      .pulse_next  (pulse_next[g])
    );
  end

  // Built from next-state pulses so it lines up with edge_pulse in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |pulse_next;
    end
  end

  assign edge_any = any_q;

endmodule

// File: tb/tb_edge_event_detector.sv
// tb/tb_edge_event_detector.sv - self-checking bench for edge_event_detector
module tb_edge_event_detector;

  localparam int ND = 3;
  localparam int PA[ND] = '{3, 1, 2};
  localparam int HA[ND] = '{0, 0, 4};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sig, rise, fall, clr;
  logic [3:0] pul [ND];
  logic [3:0] stk [ND];
  logic       anyo[ND];

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  edge_event_detector #(.WIDTH(4), .PULSE_CYCLES(3), .HOLDOFF_CYCLES(0)) u_d0 (
    .clk(clk), .rst(rst), .signal_in(sig), .mode_rise(rise), .mode_fall(fall),
    .sticky_clear(clr), .edge_pulse(pul[0]), .edge_sticky(stk[0]), .edge_any(anyo[0]));
  edge_event_detector #(.WIDTH(4), .PULSE_CYCLES(1), .HOLDOFF_CYCLES(0)) u_d1 (
    .clk(clk), .rst(rst), .signal_in(sig), .mode_rise(rise), .mode_fall(fall),
    .sticky_clear(clr), .edge_pulse(pul[1]), .edge_sticky(stk[1]), .edge_any(anyo[1]));
  edge_event_detector #(.WIDTH(4), .PULSE_CYCLES(2), .HOLDOFF_CYCLES(4)) u_d2 (
    .clk(clk), .rst(rst), .signal_in(sig), .mode_rise(rise), .mode_fall(fall),
    .sticky_clear(clr), .edge_pulse(pul[2]), .edge_sticky(stk[2]), .edge_any(anyo[2]));

  // Model: remember when each channel last accepted an edge; a pulse is live
  // for PULSE cycles after that, and a new edge is accepted once PULSE+HOLDOFF
  // cycles have passed.
  int         cyc = 0;
  int         acc [ND][4];
  bit         have[ND][4];
  logic [3:0] m_prev;
  logic [3:0] m_stk [ND];
  logic [3:0] m_pul [ND];
  logic       m_any [ND];

  always @(posedge clk) begin
    logic [3:0] q;
    cyc = cyc + 1;
    q = (sig & ~m_prev & rise) | (~sig & m_prev & fall);
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (rst) begin
          have[d][c]  = 0;
          m_stk[d][c] = 1'b0;
          m_pul[d][c] = 1'b0;
        end else begin
          if (q[c]) m_stk[d][c] = 1'b1;
          else if (clr[c]) m_stk[d][c] = 1'b0;
          if (q[c] && (!have[d][c] || (cyc - acc[d][c] >= PA[d] + HA[d]))) begin
            have[d][c] = 1;
            acc[d][c]  = cyc;
          end
          m_pul[d][c] = have[d][c] && (cyc - acc[d][c] < PA[d]);
        end
      end
      m_any[d] = rst ? 1'b0 : (|m_pul[d]);
    end
    m_prev = sig;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        total++;
        if (pul[d] !== m_pul[d]) begin
          bad++;
          $display("FAIL model_pulse d%0d t=%0t: got %b want %b", d, $time, pul[d], m_pul[d]);
        end
        total++;
        if (stk[d] !== m_stk[d]) begin
          bad++;
          $display("FAIL model_sticky d%0d t=%0t: got %b want %b", d, $time, stk[d], m_stk[d]);
        end
        total++;
        if (anyo[d] !== m_any[d]) begin
          bad++;
          $display("FAIL model_any d%0d t=%0t: got %b want %b", d, $time, anyo[d], m_any[d]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n1, n2, starts;
    logic pv;
    rst = 1'b1; sig = 4'b1111; rise = 4'b1111; fall = 4'b0000; clr = 4'b0000;
    step(2);
    chk_en = 1;
    check("reset_pulse", int'(pul[0]), 0);
    check("reset_sticky", int'(stk[0]), 0);
    rst = 1'b0;
    step(20);
    check("steady_high_pulse", int'(pul[0]), 0);
    check("steady_high_sticky", int'(stk[0]), 0);

    // ch0 rise-only, 3-cycle pulse on d0
    rise = 4'b0000; sig = 4'b0000;
    step(2);
    rise = 4'b0001; sig = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check($sformatf("rise_pulse_c%0d", i), int'(pul[0][0]), (i < 3) ? 1 : 0);
      check($sformatf("rise_any_c%0d", i), int'(anyo[0]), (i < 3) ? 1 : 0);
    end
    check("rise_sticky", int'(stk[0][0]), 1);

    // ch1 both modes, ch2 fall-only, d1 pulses of 1 cycle
    rise = 4'b0010; fall = 4'b0110;
    n1 = 0; n2 = 0;
    for (int i = 0; i < 25; i++) begin
      if (i == 0)  sig[2:1] = 2'b11;
      if (i == 10) sig[2:1] = 2'b00;
      step(1);
      n1 += int'(pul[1][1]);
      n2 += int'(pul[1][2]);
    end
    check("both_modes_pulses", n1, 2);
    check("fall_only_pulses", n2, 1);

    // ch3 toggling every cycle against 2+4 lockout on d2
    rise = 4'b1000; fall = 4'b1000;
    starts = 0; pv = pul[2][3];
    for (int i = 0; i < 30; i++) begin
      if (i < 24) sig[3] = ~sig[3];
      step(1);
      if (pul[2][3] && !pv) starts++;
      pv = pul[2][3];
    end
    check("holdoff_starts", starts, 4);
    check("holdoff_sticky", int'(stk[2][3]), 1);

    // sticky clear versus set in the same cycle
    rise = 4'b0001; fall = 4'b0000;
    clr = 4'b0001;
    step(1);
    check("clear_alone_1", int'(stk[0][0]), 0);
    clr = 4'b0000; sig[0] = 1'b0;
    step(1);
    sig[0] = 1'b1; clr = 4'b0001;
    step(1);
    check("set_wins_clear", int'(stk[0][0]), 1);
    step(1);
    check("clear_alone_2", int'(stk[0][0]), 0);
    clr = 4'b0000;
    step(4);

    // reset in the first cycle of a 3-cycle pulse
    sig[0] = 1'b0;
    step(1);
    sig[0] = 1'b1;
    step(1);
    check("pre_reset_pulse", int'(pul[0][0]), 1);
    rst = 1'b1;
    step(1);
    check("abort_pulse", int'(pul[0]), 0);
    check("abort_any", int'(anyo[0]), 0);
    check("abort_sticky", int'(stk[0]), 0);
    rst = 1'b0;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      n1 += int'(pul[0][0]);
    end
    check("no_resume", n1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
